// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// default latencies and the HI/LO staging type.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_stage_t;

    // Ops that occupy the unit for multiple cycles and must stall the front end
    function automatic logic is_long_op(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Sequential multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at acceptance into a staging register and committed
// to HI/LO when the latency counter expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    mdu_stage_t         r_stage;

    mdu_op_e            w_op;
    logic               w_long;
    mdu_stage_t         w_stage;
    logic [63:0]        w_a_sx;
    logic [63:0]        w_b_sx;
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic [31:0]        w_quo_u;
    logic [31:0]        w_rem_u;

    assign w_op      = mdu_op_e'(op);
    assign w_long    = is_long_op(w_op);
    assign busy      = r_busy;
    assign stall_req = r_busy | (start & w_long);
    assign HI        = r_hi;
    assign LO        = r_lo;

    assign w_a_sx   = {{32{A[31]}}, A};
    assign w_b_sx   = {{32{B[31]}}, B};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Raw quotient/remainder; zero-divisor and overflow cases are overridden below
    always_comb begin
        w_quo_s = '0;
        w_rem_s = '0;
        w_quo_u = '0;
        w_rem_u = '0;
        if (B != '0) begin
            w_quo_s = $signed(A) / $signed(B);
            w_rem_s = $signed(A) % $signed(B);
            w_quo_u = A / B;
            w_rem_u = A % B;
        end
    end

    // Select the result to stage; divide by zero stages the current HI/LO so
    // the commit leaves them unchanged (HI/LO cannot change while busy)
    always_comb begin
        w_stage = '{hi: r_hi, lo: r_lo};
        case (w_op)
            MDU_MULT:  w_stage = w_prod_s;
            MDU_MULTU: w_stage = w_prod_u;
            MDU_DIV: begin
                if (B == '0) begin
                    w_stage = '{hi: r_hi, lo: r_lo};
                end else if ((A == 32'h8000_0000) && (B == '1)) begin
                    w_stage = '{hi: 32'd0, lo: 32'h8000_0000};
                end else begin
                    w_stage = '{hi: w_rem_s, lo: w_quo_s};
                end
            end
            MDU_DIVU: begin
                if (B != '0) begin
                    w_stage = '{hi: w_rem_u, lo: w_quo_u};
                end
            end
            default: ;
        endcase
    end

    // Accept ops when idle, count down in-flight ops, commit HI/LO on expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_stage <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                r_hi   <= r_stage.hi;
                r_lo   <= r_stage.lo;
            end
        end else if (start) begin
            case (w_op)
                MDU_MULT, MDU_MULTU: begin
                    r_stage <= w_stage;
                    r_cnt   <= CNT_W'(MULT_CYCLES);
                    r_busy  <= 1'b1;
                end
                MDU_DIV, MDU_DIVU: begin
                    r_stage <= w_stage;
                    r_cnt   <= CNT_W'(DIV_CYCLES);
                    r_busy  <= 1'b1;
                end
                MDU_MTHI: r_hi <= A;
                MDU_MTLO: r_lo <= A;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential multiply/divide unit in the EX stage of the pipelined MIPS CPU; owns the HI and LO registers.
- Executes mult/multu/div/divu, mthi and mtlo.
- HI and LO feed the EX-stage 2:1 result muxes that serve mfhi/mflo.
- Exports busy so the hazard unit stalls the front end while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  single-cycle request qualifying op/A/B.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- A  input  32  operand rs: dividend, multiplicand, or mthi/mtlo source.
- B  input  32  operand rt: divisor or multiplier.
- busy  output  1  high while a mult/div is in flight.
- stall_req  output  1  combinational: busy | (start & op in 1..4); to hazard unit.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - HI=0, LO=0, busy=0, counter=0; staged results discarded.
  - First start is accepted on the first rising edge after reset deasserts.
- Acceptance:
  - start is sampled on the rising edge only when busy=0.
  - start while busy=1 is ignored entirely (no error, no queueing). Upstream must hold the instruction via stall_req.
- mult/multu/div/divu accepted at edge E:
  - Result is computed from the A/B sampled at E into internal staging registers hi_n/lo_n.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES); busy=1 after E.
  - Counter decrements each edge. At the edge where it reaches 0, HI<=hi_n, LO<=lo_n and busy<=0 together.
  - busy is high for exactly N cycles. HI/LO hold their old values throughout busy.
- mthi/mtlo accepted with busy=0:
  - HI<=A (mthi) or LO<=A (mtlo) at that same edge.
  - No busy, no stall; the other register is unchanged.
- Arithmetic:
  - mult: signed 32x32 -> 64; {HI,LO}=product.
  - multu: same as mult, unsigned.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0, div or divu): operation still runs the full DIV_CYCLES with busy high; HI and LO retain their prior values at completion.
- Simultaneous events:
  - Completion edge with start=1 on that same edge: the start is ignored, because busy=1 when sampled.
  - The next op can be accepted one cycle later.
- op 0 or 7 with start=1: no effect.

Decomposition:
- Shared package holds:
  - op encodings (MDU_NONE..MDU_MTLO);
  - default latency constants;
  - the 64-bit staging type.
- No sub-module required. Counter, staging and HI/LO registers are kept inline.
- A separate divider core is only justified if DIV_CYCLES is later tied to an iterative algorithm.

Test Plan:
- Reset mid-divide: start div (A=100, B=7), assert reset at cycle 4 -> HI=0, LO=0, busy=0 immediately (asynchronous); no later update of HI/LO.
- Signed mult: A=0xFFFFFFFE (-2), B=3, mult -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned mult: same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- Signed and unsigned divide:
  - div A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/2 -> LO=3, HI=1.
  - Overflow case -> LO=0x80000000, HI=0.
- Divide by zero and busy rejection:
  - Preload via mthi 0x11, mtlo 0x22; then div by 0 -> busy 10 cycles, HI=0x11, LO=0x22 afterwards.
  - mthi pulsed during that busy window is ignored.
- Back-to-back:
  - mult issued on the completion edge of a prior div is ignored.
  - Reissued the next cycle, it is accepted; stall_req is high on both attempt cycles.
